// File: rtl/uart_pkg.sv
// Shared definitions for the 8-bit UART transmitter: FSM states, line levels
// and the bit-period helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_LEVEL = 1'b1;
    localparam int   DATA_BITS  = 8;

    function automatic int bit_cycles(input int clock_rate, input int baud_rate);
        return clock_rate / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..PERIOD-1 and raises tick in the last cycle.
// restart forces the count back to zero so a new frame starts on a clean period.
module uart_baud_tick #(
    parameter int PERIOD = 10,
    parameter int WIDTH  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    logic [WIDTH-1:0] count_reg;

    assign tick = (count_reg == WIDTH'(PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (restart || tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart8_transmitter.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional even
// parity (define UART_TX_PARITY_EN), then STOP_BITS stop bits.
module uart8_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       valid,
    input  logic [7:0] in,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       out
);

    localparam int BIT_CYCLES = bit_cycles(CLOCK_RATE, BAUD_RATE);
    localparam int CNT_W      = $clog2(BIT_CYCLES * STOP_BITS);

    if (BIT_CYCLES < 2) begin : g_bad_rate
        $error("uart8_transmitter: CLOCK_RATE/BAUD_RATE must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart8_transmitter: STOP_BITS must be 1 or 2");
    end

    state_t     state_reg, state_next;
    logic [7:0] shift_reg, shift_next;
    logic [2:0] bit_reg, bit_next;
    logic       out_reg, out_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic       accept;
    logic       tick;
`ifdef UART_TX_PARITY_EN
    logic       parity_reg, parity_next;
`endif

    assign ready  = (state_reg == IDLE) && en;
    assign accept = valid && ready;
    assign busy   = busy_reg;
    assign done   = done_reg;
    assign out    = out_reg;

    // Holding the timer in restart while disabled keeps an aborted frame from
    // leaking a partial period into the next one.
    uart_baud_tick #(
        .PERIOD (BIT_CYCLES),
        .WIDTH  (CNT_W)
    ) u_baud_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (accept || !en),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            shift_reg  <= '0;
            bit_reg    <= '0;
            out_reg    <= STOP_LEVEL;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            shift_reg  <= shift_next;
            bit_reg    <= bit_next;
            out_reg    <= out_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        bit_next    = bit_reg;
        done_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        if (!en) begin
            state_next = IDLE;
            bit_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (valid) begin
                        state_next  = START;
                        shift_next  = in;
                        bit_next    = '0;
`ifdef UART_TX_PARITY_EN
                        parity_next = ^in;
`endif
                    end
                end
                START: begin
                    if (tick) state_next = DATA;
                end
                DATA: begin
                    if (tick) begin
                        if (bit_reg == 3'(DATA_BITS - 1)) begin
                            bit_next = '0;
`ifdef UART_TX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            bit_next   = bit_reg + 3'd1;
                            shift_next = shift_reg >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) state_next = STOP;
                end
                STOP: begin
                    // bit_reg counts elapsed stop bits here.
                    if (tick) begin
                        if (bit_reg == 3'(STOP_BITS - 1)) begin
                            state_next = IDLE;
                            bit_next   = '0;
                            done_next  = 1'b1;
                        end else begin
                            bit_next = bit_reg + 3'd1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        busy_next = (state_next != IDLE);
        case (state_next)
            START:   out_next = START_BIT;
            DATA:    out_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  out_next = parity_next;
`endif
            default: out_next = STOP_LEVEL;
        endcase
    end

endmodule
